// File: rtl/serial_alu_sequencer_if.sv
// serial_alu_sequencer_if: control-unit handshake, operand/result bus and one-bit slice wiring
interface serial_alu_sequencer_if #(parameter int WIDTH = 32);
   logic start;
   logic [2:0] op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic ready;
   logic done;
   logic [WIDTH-1:0] result;
   logic cout;
   logic zero;
   logic overflow;
   logic bad_op;
   logic alu_a;
   logic alu_b;
   logic alu_cin;
   logic alu_less;
   logic [2:0] alu_op;
   logic alu_r;
   logic alu_cout;
   // master is the environment: the control unit plus the slice outputs it returns
   modport master (output start, op, a, b, alu_r, alu_cout,
                   input ready, done, result, cout, zero, overflow, bad_op,
                         alu_a, alu_b, alu_cin, alu_less, alu_op);
   modport slave (input start, op, a, b, alu_r, alu_cout,
                  output ready, done, result, cout, zero, overflow, bad_op,
                         alu_a, alu_b, alu_cin, alu_less, alu_op);
endinterface

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: runs a WIDTH-bit AND/OR/ADD/SUB/SLT through one external ALU slice, LSB first
module serial_alu_sequencer #(parameter int WIDTH = 32) (
   input logic clk,
   input logic reset,
   serial_alu_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, fin;
   logic [2:0] op_r;
   logic [CW-1:0] bit_cnt;
   logic carry, legal, slt, arith, run;
   assign legal = op_r inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
   assign slt = op_r == 3'b111;
   assign arith = op_r == 3'b010 || op_r == 3'b110;
   // illegal ops keep the slice idle while still spending the full RUN length
   assign run = state == RUN && legal;
   assign bus.alu_a = run & a_sh[0];
   assign bus.alu_b = run & b_sh[0];
   assign bus.alu_cin = run & carry;
   assign bus.alu_less = 1'b0;
   assign bus.alu_op = run ? (slt ? 3'b110 : op_r) : 3'b000;
   // value presented at done; SLT takes the raw sign of a-b from the last slice pass
   assign fin = !legal ? '0 : slt ? {{(WIDTH-1){1'b0}}, bus.alu_r} : {bus.alu_r, res_sh[WIDTH-1:1]};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         a_sh <= '0;
         b_sh <= '0;
         res_sh <= '0;
         op_r <= '0;
         bit_cnt <= '0;
         carry <= 1'b0;
         bus.ready <= 1'b1;
         bus.done <= 1'b0;
         bus.result <= '0;
         bus.cout <= 1'b0;
         bus.zero <= 1'b1;
         bus.overflow <= 1'b0;
         bus.bad_op <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state <= RUN;
               a_sh <= bus.a;
               b_sh <= bus.b;
               op_r <= bus.op;
               bit_cnt <= '0;
               carry <= bus.op[2];
               res_sh <= '0;
               bus.ready <= 1'b0;
               bus.result <= '0;
               bus.cout <= 1'b0;
               bus.zero <= 1'b1;
               bus.overflow <= 1'b0;
               bus.bad_op <= 1'b0;
            end
            RUN: begin
               carry <= bus.alu_cout;
               res_sh <= {bus.alu_r & !slt, res_sh[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
                  bus.done <= 1'b1;
                  bus.result <= fin;
                  bus.zero <= fin == '0;
                  bus.cout <= (arith || slt) & bus.alu_cout;
                  bus.overflow <= arith & (carry ^ bus.alu_cout);
                  bus.bad_op <= !legal;
               end
            end
            DONE: begin
               state <= IDLE;
               bus.done <= 1'b0;
               bus.ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: drives directed and random ops through the sequencer plus a behavioural slice,
// comparing against a whole-word arithmetic model
module tb_serial_alu_sequencer;
   localparam int W = 32;
   logic clk = 1'b0;
   logic reset;
   int n_tests = 0;
   int n_fail = 0;
   serial_alu_sequencer_if #(.WIDTH(W)) bus ();
   serial_alu_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // one-bit slice: op[2] inverts b, op[1:0] selects AND/OR/ADD/LESS
   logic bb, sum;
   always_comb begin
      bb = bus.alu_b ^ bus.alu_op[2];
      sum = bus.alu_a ^ bb ^ bus.alu_cin;
      bus.alu_cout = (bus.alu_a & bb) | (bus.alu_a & bus.alu_cin) | (bb & bus.alu_cin);
      bus.alu_r = bus.alu_op[1:0] == 2'b00 ? bus.alu_a & bb :
                  bus.alu_op[1:0] == 2'b01 ? bus.alu_a | bb :
                  bus.alu_op[1:0] == 2'b10 ? sum : bus.alu_less;
   end
   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic v, output logic bad);
      logic [W:0] s;
      r = '0; c = 1'b0; v = 1'b0; bad = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; c = s[W];
            v = a[W-1] == b[W-1] && r[W-1] != a[W-1];
         end
         3'b110: begin
            s = {1'b0, a} + {1'b0, ~b} + 1;
            r = s[W-1:0]; c = s[W];
            v = a[W-1] != b[W-1] && r[W-1] != a[W-1];
         end
         3'b111: begin
            s = {1'b0, a} + {1'b0, ~b} + 1;
            r = {{(W-1){1'b0}}, s[W-1]}; c = s[W];
         end
         default: bad = 1'b1;
      endcase
   endfunction
   task automatic wait_ready();
      for (int i = 0; i < 4 * W && !bus.ready; i++) @(negedge clk);
      check("ready_wait", {31'b0, bus.ready}, 1);
   endtask
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] er;
      logic ec, ev, eb, legal, cin0;
      logic [2:0] eop;
      int lat, bad_aop;
      model(op, a, b, er, ec, ev, eb);
      legal = !eb;
      eop = !legal ? 3'b000 : op == 3'b111 ? 3'b110 : op;
      wait_ready();
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk);
      lat = 1;
      bad_aop = 0;
      @(negedge clk);
      bus.start = 1'b0;
      cin0 = bus.alu_cin;
      while (!bus.done && lat < 3 * W) begin
         if (bus.alu_op !== eop) bad_aop++;
         @(negedge clk);
         lat++;
      end
      check("latency", lat, W + 1);
      check("alu_op_run", bad_aop, 0);
      check("cin_first", {31'b0, cin0}, {31'b0, legal & op[2]});
      check("result", bus.result, er);
      check("cout", {31'b0, bus.cout}, {31'b0, ec});
      check("overflow", {31'b0, bus.overflow}, {31'b0, ev});
      check("zero", {31'b0, bus.zero}, {31'b0, er == '0});
      check("bad_op", {31'b0, bus.bad_op}, {31'b0, eb});
      check("ready_at_done", {31'b0, bus.ready}, 0);
      @(negedge clk);
      check("done_pulse", {30'b0, bus.done, bus.ready}, 2'b01);
      check("result_hold", bus.result, er);
   endtask
   initial begin
      logic [2:0] ops [6];
      logic [W-1:0] corners [4];
      logic [W-1:0] ra, rb;
      int dones;
      ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011};
      corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'b0, bus.ready}, 1);
      check("rst_flags", {28'b0, bus.done, bus.cout, bus.overflow, bus.bad_op}, 0);
      check("rst_zero", {31'b0, bus.zero}, 1);
      check("rst_result", bus.result, 0);
      check("rst_alu", {25'b0, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_less, bus.alu_op}, 0);
      reset = 1'b0;
      @(negedge clk);
      run_op(3'b010, 32'h7FFF_FFFF, 32'h1);
      run_op(3'b110, 32'd5, 32'd5);
      run_op(3'b111, 32'hFFFF_FFFE, 32'd3);
      run_op(3'b111, 32'd3, 32'hFFFF_FFFE);
      run_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
      run_op(3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF);
      run_op(3'b110, 32'h8000_0000, 32'h1);
      run_op(3'b101, 32'h1234_5678, 32'h1);
      wait_ready();
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd23;
      @(posedge clk);
      dones = 0;
      for (int i = 0; i < 2 * (W + 2) - 1; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      bus.start = 1'b0;
      check("held_start_dones", dones, 2);
      check("held_start_result", bus.result, 32'd123);
      wait_ready();
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd7; bus.b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_ready", {31'b0, bus.ready}, 1);
      check("abort_result", bus.result, 0);
      check("abort_alu_op", {29'b0, bus.alu_op}, 0);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < W + 5; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_op(3'b011, 32'hDEAD_BEEF, 32'h1);
      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(3) == 0) ra = corners[$urandom_range(3)];
         if ($urandom_range(3) == 0) rb = corners[$urandom_range(3)];
         if ($urandom_range(5) == 0) rb = ra;
         run_op(ops[$urandom_range(5)], ra, rb);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
